// File: rtl/jpeg_quant_pkg.sv
// rtl/jpeg_quant_pkg.sv - shared constants, Annex K default Q tables and reciprocal helper
package jpeg_quant_pkg;

    localparam int BLK_SZ = 64;
    localparam int IDX_W  = 6;

    localparam logic [7:0] LUMA_Q [BLK_SZ] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam logic [7:0] CHROMA_Q [BLK_SZ] = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    function automatic logic [7:0] default_q(input int tbl, input int idx);
        logic [IDX_W-1:0] a;
        a = idx[IDX_W-1:0];
        return (tbl == 0) ? LUMA_Q[a] : CHROMA_Q[a];
    endfunction

    // M(q) = ceil(2^s / q); q of 0 is treated as 1, matching how the tables store it.
    function automatic longint unsigned recip(input int q, input int s);
        longint unsigned one;
        longint unsigned qq;
        one = 64'd1;
        qq  = (q < 1) ? 64'd1 : 64'(q);
        return ((one << s) + qq - 64'd1) / qq;
    endfunction

endpackage

// File: rtl/jpeg_qtable_bank.sv
// rtl/jpeg_qtable_bank.sv - NUM_TBL x 64 x 8 Q register file, one write port, one registered read port
module jpeg_qtable_bank
    import jpeg_quant_pkg::*;
#(
    parameter int NUM_TBL = 2,
    parameter int TSEL_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TSEL_W-1:0] wr_tsel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [TSEL_W-1:0] rd_tsel,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [7:0]        rd_q
);

    logic [7:0] mem [NUM_TBL][BLK_SZ];
    logic       wr_ok;
    logic [7:0] wr_val;

    assign wr_ok  = wr_en && ({1'b0, wr_tsel} < (TSEL_W+1)'(NUM_TBL));
    assign wr_val = (wr_data == 8'd0) ? 8'd1 : wr_data;

    // The read samples the array before this edge's write lands, so a
    // same-entry collision returns the old Q value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TBL; t++) begin
                for (int i = 0; i < BLK_SZ; i++) begin
                    mem[t][i] <= default_q(t, i);
                end
            end
            rd_q <= 8'd1;
        end else begin
            if (wr_ok) begin
                mem[wr_tsel][wr_addr] <= wr_val;
            end
            if (rd_en) begin
                rd_q <= mem[rd_tsel][rd_addr];
            end
        end
    end

endmodule

// File: rtl/jpeg_quant_stream.sv
// rtl/jpeg_quant_stream.sv - 3-stage streaming JPEG quantizer with round-half-away and saturation
module jpeg_quant_stream
    import jpeg_quant_pkg::*;
#(
    parameter int IN_W    = 12,
    parameter int OUT_W   = 8,
    parameter int NUM_TBL = 2,
    parameter int TSEL_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [TSEL_W-1:0] in_tsel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    input  logic              cfg_we,
    input  logic [TSEL_W-1:0] cfg_tsel,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [7:0]        cfg_data
);

    localparam int S    = IN_W + 8;
    localparam int M_W  = S + 1;
    localparam int P_W  = IN_W + M_W;
    localparam int MAXV = (1 << (OUT_W - 1)) - 1;

    logic              en;
    logic              xfer;
    logic [IDX_W-1:0]  cnt;
    logic [TSEL_W-1:0] tsel_lat;
    logic [TSEL_W-1:0] tsel_in_c;
    logic [TSEL_W-1:0] tsel_rd;

    logic [IN_W:0]     x_ext;
    logic [IN_W:0]     x_neg;
    logic [IN_W-1:0]   x_abs;

    logic              v1, neg1;
    logic [IDX_W-1:0]  idx1;
    logic [IN_W-1:0]   abs1;
    logic [7:0]        q1;

    logic [IN_W-1:0]   n_c;
    logic [M_W-1:0]    m_c;
    logic [P_W-1:0]    prod_c;

    logic              v2, neg2;
    logic [IDX_W-1:0]  idx2;
    logic [P_W-1:0]    prod2;

    logic [IN_W:0]     r_mag;
    logic [OUT_W-1:0]  mag_c;
    logic [OUT_W-1:0]  res_c;
    logic              unused_bits;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign xfer     = in_valid && en;

    assign tsel_in_c = ({1'b0, in_tsel} >= (TSEL_W+1)'(NUM_TBL)) ? TSEL_W'(NUM_TBL - 1) : in_tsel;
    assign tsel_rd   = (cnt == '0) ? tsel_in_c : tsel_lat;

    jpeg_qtable_bank #(
        .NUM_TBL (NUM_TBL),
        .TSEL_W  (TSEL_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_we),
        .wr_tsel (cfg_tsel),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_en   (xfer),
        .rd_tsel (tsel_rd),
        .rd_addr (cnt),
        .rd_q    (q1)
    );

    // Widen by one bit so the most-negative input has a representable magnitude.
    assign x_ext = {in_data[IN_W-1], in_data};
    assign x_neg = -x_ext;
    assign x_abs = in_data[IN_W-1] ? x_neg[IN_W-1:0] : in_data;

    // Constant ROM of M(q) for every 8-bit q; entry 0 is never addressed.
    logic [M_W-1:0] recip_rom [256];
    for (genvar k = 0; k < 256; k++) begin : g_recip
        assign recip_rom[k] = M_W'(recip(k, S));
    end

    // |x| + floor(q/2) stays below 2^IN_W for any legal input and q <= 255.
    assign n_c    = abs1 + IN_W'(q1[7:1]);
    assign m_c    = recip_rom[q1];
    assign prod_c = P_W'(n_c) * P_W'(m_c);

    always_comb begin
        r_mag = prod2[P_W-1:S];
        mag_c = r_mag[OUT_W-1:0];
        if (r_mag > (IN_W+1)'(MAXV)) begin
            mag_c = OUT_W'(MAXV);
        end
        res_c = neg2 ? -mag_c : mag_c;
    end

    assign unused_bits = ^{prod2[S-1:0], x_neg[IN_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tsel_lat  <= '0;
            v1        <= 1'b0;
            neg1      <= 1'b0;
            idx1      <= '0;
            abs1      <= '0;
            v2        <= 1'b0;
            neg2      <= 1'b0;
            idx2      <= '0;
            prod2     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (xfer) begin
                cnt <= cnt + IDX_W'(1);
                if (cnt == '0) begin
                    tsel_lat <= tsel_in_c;
                end
            end
            if (en) begin
                v1        <= xfer;
                neg1      <= in_data[IN_W-1];
                idx1      <= cnt;
                abs1      <= x_abs;
                v2        <= v1;
                neg2      <= neg1;
                idx2      <= idx1;
                prod2     <= prod_c;
                out_valid <= v2;
                out_data  <= res_c;
                out_idx   <= idx2;
                out_last  <= v2 && (idx2 == IDX_W'(BLK_SZ - 1));
            end
        end
    end

endmodule

// File: tb/tb_jpeg_quant_stream.sv
// tb/tb_jpeg_quant_stream.sv - self-checking bench: directed tables, corner sequences, random vs model
module tb_jpeg_quant_stream;

    localparam int IN_W    = 12;
    localparam int OUT_W   = 8;
    localparam int NUM_TBL = 2;
    localparam int TSEL_W  = 1;
    localparam int MAXV    = (1 << (OUT_W - 1)) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [TSEL_W-1:0] in_tsel;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [5:0]        out_idx;
    logic              out_last;
    logic              cfg_we;
    logic [TSEL_W-1:0] cfg_tsel;
    logic [5:0]        cfg_addr;
    logic [7:0]        cfg_data;

    jpeg_quant_stream #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_TBL(NUM_TBL), .TSEL_W(TSEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tsel(in_tsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .cfg_we(cfg_we), .cfg_tsel(cfg_tsel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    typedef struct { int d; int idx; int last; } res_t;
    typedef struct { int x; int exp; } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   m_tab [NUM_TBL][64];
    int   m_cnt;
    int   m_tsel;
    int   rdy_mode = 0;
    vec_t vecs [10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int quant(input int x, input int q);
        int a, r;
        a = (x < 0) ? -x : x;
        r = (a + q / 2) / q;
        if (r > MAXV) r = MAXV;
        return (x < 0) ? -r : r;
    endfunction

    function automatic void model_reset();
        int luma [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55,
                          14,13,16,24,40,57,69,56, 14,17,22,29,51,87,80,62,
                          18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
                          49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
        int chroma [64];
        for (int i = 0; i < 64; i++) chroma[i] = 99;
        chroma[0] = 17; chroma[1] = 18; chroma[2] = 24; chroma[3] = 47;
        chroma[8] = 18; chroma[9] = 21; chroma[10] = 26; chroma[11] = 66;
        chroma[16] = 24; chroma[17] = 26; chroma[18] = 56; chroma[24] = 47; chroma[25] = 66;
        for (int t = 0; t < NUM_TBL; t++)
            for (int i = 0; i < 64; i++)
                m_tab[t][i] = (t == 0) ? luma[i] : chroma[i];
        m_cnt  = 0;
        m_tsel = 0;
        exp_q.delete();
    endfunction

    // Reference monitor: decides transfers from the handshake seen just before each edge.
    initial begin
        res_t h, cur, e;
        int   stall_prev;
        int   x;
        stall_prev = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                stall_prev = 0;
            end else begin
                if (stall_prev != 0) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_data", int'($signed(out_data)), h.d);
                    check("hold_idx", int'(out_idx), h.idx);
                    check("hold_last", int'(out_last), h.last);
                end
                stall_prev = (out_valid && !out_ready) ? 1 : 0;
                h = '{int'($signed(out_data)), int'(out_idx), int'(out_last)};
                check("in_ready", int'(in_ready), (!out_valid || out_ready) ? 1 : 0);
                if (out_valid && out_ready) begin
                    cur = h;
                    got_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_unexpected: got idx %0d data %0d, expected no output", cur.idx, cur.d);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", cur.d, e.d);
                        check("out_idx", cur.idx, e.idx);
                        check("out_last", cur.last, e.last);
                    end
                end
                if (in_valid && in_ready) begin
                    if (m_cnt == 0) m_tsel = (int'(in_tsel) >= NUM_TBL) ? NUM_TBL - 1 : int'(in_tsel);
                    x = int'($signed(in_data));
                    exp_q.push_back('{quant(x, m_tab[m_tsel][m_cnt]), m_cnt, (m_cnt == 63) ? 1 : 0});
                    m_cnt = (m_cnt + 1) % 64;
                end
                if (cfg_we && int'(cfg_tsel) < NUM_TBL)
                    m_tab[cfg_tsel][cfg_addr] = (cfg_data == 8'd0) ? 1 : int'(cfg_data);
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic send(input int x, input int ts);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(x);
        in_tsel  = TSEL_W'(ts);
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int rand_x();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4095)) - 2048;
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    task automatic send_rand(input int count);
        for (int i = 0; i < count; i++) send(rand_x(), int'($urandom_range(0, 1)));
    endtask

    task automatic cfg_write(input int t, input int a, input int d);
        cfg_we   = 1'b1;
        cfg_tsel = TSEL_W'(t);
        cfg_addr = 6'(a);
        cfg_data = 8'(d);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        vecs[0] = '{-415, -26}; vecs[1] = '{-30, -3};  vecs[2] = '{15, 2};
        vecs[3] = '{8, 1};      vecs[4] = '{-12, -1};  vecs[5] = '{19, 0};
        vecs[6] = '{2047, 40};  vecs[7] = '{-2048, -34}; vecs[8] = '{0, 0};
        vecs[9] = '{-6, -1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tsel = '0;
        cfg_we = 1'b0; cfg_tsel = '0; cfg_addr = '0; cfg_data = '0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Default luma, latency, then full blocks with restart.
        got_q.delete();
        send(vecs[0].x, 0);
        @(negedge clk); check("lat_c1_valid", int'(out_valid), 0);
        @(negedge clk); check("lat_c2_valid", int'(out_valid), 0);
        @(negedge clk); check("lat_c3_valid", int'(out_valid), 1);
        check("lat_c3_data", int'($signed(out_data)), -26);
        check("lat_c3_idx", int'(out_idx), 0);
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) send(vecs[i].x, 0);
        send_rand(54);
        send_rand(64);
        drain();
        check("a_count", got_q.size(), 128);
        for (int i = 0; i < 10; i++) begin
            check("a_vec_data", got_q[i].d, vecs[i].exp);
            check("a_vec_idx", got_q[i].idx, i);
        end
        nl = 0;
        foreach (got_q[i]) nl += got_q[i].last;
        check("a_last_count", nl, 2);
        check("a_last_63", got_q[63].last, 1);
        check("a_restart_idx", got_q[64].idx, 0);

        // q=1 saturation and zero-stored-as-one.
        cfg_write(0, 0, 1);
        cfg_write(0, 1, 1);
        cfg_write(0, 2, 0);
        got_q.delete();
        send(2047, 0);
        send(-2047, 0);
        send(5, 0);
        send_rand(61);
        drain();
        check("b_sat_pos", got_q[0].d, 127);
        check("b_sat_neg", got_q[1].d, -127);
        check("b_zero_q", got_q[2].d, 5);

        // Chroma latched on the first coefficient, tsel toggling mid-block.
        got_q.delete();
        send(25, 1); send_rand(63);
        send(8, 1);  send_rand(63);
        send(9, 1);  send_rand(63);
        drain();
        check("c_x25", got_q[0].d, 1);
        check("c_x8", got_q[64].d, 0);
        check("c_x9", got_q[128].d, 1);

        // Random backpressure, bubbles and mid-block table writes.
        rdy_mode = 1;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) cfg_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                                                     int'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_tsel = TSEL_W'(m_tsel); cfg_addr = 6'(m_cnt);
                cfg_data = 8'($urandom_range(0, 40));
            end
            send(rand_x(), int'($urandom_range(0, 1)));
            cfg_we = 1'b0;
        end
        drain();
        rdy_mode = 0;
        @(posedge clk); #1;

        // Reset after coefficient 30 of a block.
        cfg_write(0, 0, 1);
        send_rand(31);
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_valid", int'(out_valid), 0);
        check("e_rst_data", int'(out_data), 0);
        check("e_rst_idx", int'(out_idx), 0);
        check("e_rst_last", int'(out_last), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        send(-415, 0);
        send_rand(63);
        drain();
        check("e_first_data", got_q[0].d, -26);
        check("e_first_idx", got_q[0].idx, 0);
        check("e_count", got_q.size(), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
